store_unit_ctrl: RTL and testbench

Store-side control stage of the load/store unit. It sits directly upstream of the store buffer: it accepts issued stores, aligns data and byte enables, requests address translation from the DTLB and pushes the translated store into the speculative queue. It returns the completion or exception for each store to the scoreboard one cycle after the store is resolved.

---
 rtl/store_unit_ctrl.sv | 178 +++++++++++++++++
 tb/tb_store_unit_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit_ctrl.sv
// Store-side control stage: accepts issued stores, aligns data/byte enables,
// requests DTLB translation and pushes into the store buffer.
// Optional misalignment check enabled by defining STORE_UNIT_MISALIGN_CHECK_EN.
module store_unit_ctrl #(
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [63:0]              vaddr_i,
    input  logic [63:0]              data_i,
    input  logic [1:0]               size_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     pop_st_o,
    output logic                     translation_req_o,
    output logic [63:0]              vaddr_o,
    input  logic                     dtlb_hit_i,
    input  logic [63:0]              paddr_i,
    input  logic                     ex_i,
    input  logic                     st_ready_i,
    output logic                     st_valid_o,
    output logic                     st_valid_without_flush_o,
    output logic [63:0]              st_paddr_o,
    output logic [63:0]              st_data_o,
    output logic [7:0]               st_be_o,
    output logic [1:0]               st_size_o,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     ex_valid_o,
    output logic                     ex_misaligned_o
);

    typedef enum logic [1:0] {
        IDLE             = 2'd0,
        VALID_STORE      = 2'd1,
        WAIT_STORE_READY = 2'd2
    } state_e;

    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] ones;
        case (size)
            2'd0:    ones = 8'h01;
            2'd1:    ones = 8'h03;
            2'd2:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones << off;
    endfunction

    // Upper half of the doubled word shifted left is the byte rotation.
    function automatic logic [63:0] rotl_bytes(input logic [63:0] d, input logic [2:0] off);
        logic [127:0] w;
        w = {d, d} << {off, 3'b000};
        return w[127:64];
    endfunction

`ifdef STORE_UNIT_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd1:    return off[0] != 1'b0;
            2'd2:    return off[1:0] != 2'b00;
            2'd3:    return off != 3'b000;
            default: return 1'b0;
        endcase
    endfunction
`endif

    state_e                   state_q, state_d;
    logic [63:0]              vaddr_q, vaddr_d, data_q, data_d, paddr_q, paddr_d;
    logic [7:0]               be_q, be_d;
    logic [1:0]               size_q, size_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d, trans_id_q, trans_id_d;
    logic                     mis_q, mis_d;
    logic                     valid_q, valid_d, ex_valid_q, ex_valid_d, ex_mis_q, ex_mis_d;
    logic                     mis_in_s, hit_s, fault_s, push_s, mis_res_s, resolve_s, accept_s;

`ifdef STORE_UNIT_MISALIGN_CHECK_EN
    assign mis_in_s = misaligned(size_i, vaddr_i[2:0]);
`else
    assign mis_in_s = 1'b0;
`endif

    // Resolve/accept decode, store-buffer handshake and next-state computation.
    always_comb begin
        translation_req_o = (state_q == VALID_STORE) && !mis_q;
        hit_s     = translation_req_o && dtlb_hit_i;
        fault_s   = hit_s && ex_i;
        push_s    = (hit_s && !ex_i && st_ready_i) ||
                    ((state_q == WAIT_STORE_READY) && st_ready_i);
        mis_res_s = (state_q == VALID_STORE) && mis_q;
        resolve_s = fault_s || push_s || mis_res_s;
        accept_s  = valid_i && !flush_i && ((state_q == IDLE) || resolve_s);

        pop_st_o                 = accept_s;
        st_valid_without_flush_o = push_s;
        st_valid_o               = push_s && !flush_i;
        st_paddr_o               = (state_q == WAIT_STORE_READY) ? paddr_q : paddr_i;
        vaddr_o                  = vaddr_q;
        st_data_o                = data_q;
        st_be_o                  = be_q;
        st_size_o                = size_q;

        vaddr_d = vaddr_q;
        data_d  = data_q;
        be_d    = be_q;
        size_d  = size_q;
        id_d    = id_q;
        mis_d   = mis_q;
        if (accept_s) begin
            vaddr_d = vaddr_i;
            data_d  = rotl_bytes(data_i, vaddr_i[2:0]);
            be_d    = be_gen(size_i, vaddr_i[2:0]);
            size_d  = size_i;
            id_d    = trans_id_i;
            mis_d   = mis_in_s;
        end else begin
            mis_d   = mis_q;
        end

        paddr_d = (hit_s && !ex_i && !st_ready_i) ? paddr_i : paddr_q;

        // A flush suppresses the in-flight result; an already registered one still shows.
        valid_d    = resolve_s && !flush_i;
        ex_valid_d = (fault_s || mis_res_s) && !flush_i;
        ex_mis_d   = mis_res_s && !flush_i;
        trans_id_d = resolve_s ? id_q : trans_id_q;

        if (flush_i) begin
            state_d = IDLE;
        end else if (accept_s) begin
            state_d = VALID_STORE;
        end else if (resolve_s) begin
            state_d = IDLE;
        end else if (hit_s && !ex_i && !st_ready_i) begin
            state_d = WAIT_STORE_READY;
        end else begin
            state_d = state_q;
        end
    end

    // State, latched store fields and registered scoreboard result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vaddr_q    <= 64'd0;
            data_q     <= 64'd0;
            paddr_q    <= 64'd0;
            be_q       <= 8'd0;
            size_q     <= 2'd0;
            id_q       <= '0;
            mis_q      <= 1'b0;
            valid_q    <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_mis_q   <= 1'b0;
            trans_id_q <= '0;
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            data_q     <= data_d;
            paddr_q    <= paddr_d;
            be_q       <= be_d;
            size_q     <= size_d;
            id_q       <= id_d;
            mis_q      <= mis_d;
            valid_q    <= valid_d;
            ex_valid_q <= ex_valid_d;
            ex_mis_q   <= ex_mis_d;
            trans_id_q <= trans_id_d;
        end
    end

    assign valid_o         = valid_q;
    assign ex_valid_o      = ex_valid_q;
    assign ex_misaligned_o = ex_mis_q;
    assign trans_id_o      = trans_id_q;

endmodule

// File: tb/tb_store_unit_ctrl.sv
// Directed bench for store_unit_ctrl with a result scoreboard queue.
module tb_store_unit_ctrl;

    localparam int TW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i, valid_i, dtlb_hit_i, ex_i, st_ready_i;
    logic [63:0]   vaddr_i, data_i, paddr_i;
    logic [1:0]    size_i;
    logic [TW-1:0] trans_id_i;
    logic          pop_st_o, translation_req_o, st_valid_o, st_valid_without_flush_o;
    logic [63:0]   vaddr_o, st_paddr_o, st_data_o;
    logic [7:0]    st_be_o;
    logic [1:0]    st_size_o;
    logic          valid_o, ex_valid_o, ex_misaligned_o;
    logic [TW-1:0] trans_id_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [TW-1:0] id;
        logic          ex;
        logic          mis;
    } res_t;
    res_t sb[$];

    always #5 clk_i = ~clk_i;

    store_unit_ctrl #(.TRANS_ID_BITS(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .vaddr_i(vaddr_i), .data_i(data_i), .size_i(size_i), .trans_id_i(trans_id_i),
        .pop_st_o(pop_st_o), .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
        .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i), .ex_i(ex_i), .st_ready_i(st_ready_i),
        .st_valid_o(st_valid_o), .st_valid_without_flush_o(st_valid_without_flush_o),
        .st_paddr_o(st_paddr_o), .st_data_o(st_data_o), .st_be_o(st_be_o),
        .st_size_o(st_size_o), .valid_o(valid_o), .trans_id_o(trans_id_o),
        .ex_valid_o(ex_valid_o), .ex_misaligned_o(ex_misaligned_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush_i = 1'b0; valid_i = 1'b0; dtlb_hit_i = 1'b0; ex_i = 1'b0; st_ready_i = 1'b1;
        vaddr_i = 64'd0; data_i = 64'd0; paddr_i = 64'd0; size_i = 2'd0; trans_id_i = '0;
    endtask

    task automatic issue(input logic [63:0] va, input logic [63:0] d,
                         input logic [1:0] sz, input logic [TW-1:0] id);
        valid_i = 1'b1; vaddr_i = va; data_i = d; size_i = sz; trans_id_i = id;
    endtask

    // Sample mid-cycle; every presented result is matched against the scoreboard.
    task automatic sample();
        res_t e;
        @(negedge clk_i);
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("res_id",  64'(trans_id_o),      64'(e.id));
                chk("res_ex",  64'(ex_valid_o),      64'(e.ex));
                chk("res_mis", 64'(ex_misaligned_o), 64'(e.mis));
            end
        end
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        sample();
        chk("rst_valid_o",     64'(valid_o), 64'd0);
        chk("rst_ex_valid",    64'(ex_valid_o), 64'd0);
        chk("rst_ex_mis",      64'(ex_misaligned_o), 64'd0);
        chk("rst_trans_id",    64'(trans_id_o), 64'd0);
        chk("rst_st_valid",    64'(st_valid_o), 64'd0);
        chk("rst_st_vwof",     64'(st_valid_without_flush_o), 64'd0);
        chk("rst_treq",        64'(translation_req_o), 64'd0);
        chk("rst_pop",         64'(pop_st_o), 64'd0);
        next(); next();
        rst_ni = 1'b1;
        next();

        // Byte store at offset 3
        issue(64'h1003, 64'hAB, 2'd0, 3'd5);
        sample();
        chk("b_pop", 64'(pop_st_o), 64'd1);
        next();
        idle();
        dtlb_hit_i = 1'b1; paddr_i = 64'h8000_1003;
        sb.push_back(res_t'{3'd5, 1'b0, 1'b0});
        sample();
        chk("b_treq",   64'(translation_req_o), 64'd1);
        chk("b_vaddr",  vaddr_o, 64'h1003);
        chk("b_push",   64'(st_valid_o), 64'd1);
        chk("b_be",     64'(st_be_o), 64'h08);
        chk("b_data",   st_data_o, 64'hAB00_0000);
        chk("b_paddr",  st_paddr_o, 64'h8000_1003);
        chk("b_size",   64'(st_size_o), 64'd0);
        next();
        idle();
        sample();
        chk("b_valid_o", 64'(valid_o), 64'd1);
        next();
        sample();
        chk("b_pulse", 64'(valid_o), 64'd0);
        next();

        // Back-to-back double stores, IDs 1..3
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k < 3) issue(64'h100 + 64'(8 * k), 64'h0123_4567_89AB_CDE0 + 64'(k), 2'd3, TW'(k + 1));
            if (k > 0) begin
                dtlb_hit_i = 1'b1;
                paddr_i = 64'h9000_0100 + 64'(8 * (k - 1));
                sb.push_back(res_t'{TW'(k), 1'b0, 1'b0});
            end
            sample();
            chk("bb_pop", 64'(pop_st_o), (k < 3) ? 64'd1 : 64'd0);
            if (k > 0) begin
                chk("bb_push",  64'(st_valid_o), 64'd1);
                chk("bb_data",  st_data_o, 64'h0123_4567_89AB_CDE0 + 64'(k - 1));
                chk("bb_paddr", st_paddr_o, 64'h9000_0100 + 64'(8 * (k - 1)));
                chk("bb_be",    64'(st_be_o), 64'hFF);
            end
            if (k >= 2) chk("bb_valid_o", 64'(valid_o), 64'd1);
            next();
        end
        idle();
        sample();
        chk("bb_valid_last", 64'(valid_o), 64'd1);
        next();
        sample();
        chk("bb_pulse", 64'(valid_o), 64'd0);
        next();

        // Backpressure: ready low for the hit cycle and three more
        issue(64'h200, 64'h1122_3344, 2'd2, 3'd4);
        sample();
        chk("bp_pop", 64'(pop_st_o), 64'd1);
        next();
        idle();
        dtlb_hit_i = 1'b1; paddr_i = 64'hA000_0200; st_ready_i = 1'b0;
        sample();
        chk("bp_hit_treq", 64'(translation_req_o), 64'd1);
        chk("bp_hit_push", 64'(st_valid_o), 64'd0);
        next();
        for (int j = 0; j < 3; j++) begin
            idle();
            st_ready_i = 1'b0;
            if (j == 1) issue(64'h500, 64'h55, 2'd0, 3'd0);
            sample();
            chk("bp_wait_treq",  64'(translation_req_o), 64'd0);
            chk("bp_wait_push",  64'(st_valid_o), 64'd0);
            chk("bp_wait_pop",   64'(pop_st_o), 64'd0);
            chk("bp_wait_valid", 64'(valid_o), 64'd0);
            next();
        end
        idle();
        sb.push_back(res_t'{3'd4, 1'b0, 1'b0});
        sample();
        chk("bp_push",  64'(st_valid_o), 64'd1);
        chk("bp_paddr", st_paddr_o, 64'hA000_0200);
        chk("bp_be",    64'(st_be_o), 64'h0F);
        chk("bp_data",  st_data_o, 64'h1122_3344);
        next();
        idle();
        sample();
        chk("bp_valid_o", 64'(valid_o), 64'd1);
        next();

        // Page fault, then a flush while its result is on valid_o
        issue(64'h300, 64'h77, 2'd3, 3'd6);
        sample();
        next();
        idle();
        dtlb_hit_i = 1'b1; ex_i = 1'b1; paddr_i = 64'hC000_0300;
        sb.push_back(res_t'{3'd6, 1'b1, 1'b0});
        sample();
        chk("pf_push", 64'(st_valid_o), 64'd0);
        chk("pf_vwof", 64'(st_valid_without_flush_o), 64'd0);
        next();
        idle();
        flush_i = 1'b1;
        sample();
        chk("pf_valid_o",  64'(valid_o), 64'd1);
        chk("pf_ex_valid", 64'(ex_valid_o), 64'd1);
        next();
        idle();
        sample();
        chk("pf_pulse", 64'(valid_o), 64'd0);
        next();

        // Flush in the hit cycle
        issue(64'h400, 64'h99, 2'd3, 3'd7);
        sample();
        next();
        idle();
        dtlb_hit_i = 1'b1; paddr_i = 64'hD000_0400; flush_i = 1'b1;
        sample();
        chk("fl_push", 64'(st_valid_o), 64'd0);
        chk("fl_vwof", 64'(st_valid_without_flush_o), 64'd1);
        next();
        idle();
        sample();
        chk("fl_no_result", 64'(valid_o), 64'd0);
        chk("fl_idle_treq", 64'(translation_req_o), 64'd0);
        next();

        // Word store at vaddr 0x2
        issue(64'h2, 64'h1122_3344, 2'd2, 3'd2);
        sample();
        chk("ma_pop", 64'(pop_st_o), 64'd1);
        next();
        idle();
`ifdef STORE_UNIT_MISALIGN_CHECK_EN
        sb.push_back(res_t'{3'd2, 1'b1, 1'b1});
        sample();
        chk("ma_treq", 64'(translation_req_o), 64'd0);
        chk("ma_push", 64'(st_valid_o), 64'd0);
`else
        dtlb_hit_i = 1'b1; paddr_i = 64'hB000_0002;
        sb.push_back(res_t'{3'd2, 1'b0, 1'b0});
        sample();
        chk("ma_push", 64'(st_valid_o), 64'd1);
        chk("ma_be",   64'(st_be_o), 64'h3C);
        chk("ma_data", st_data_o, 64'h0000_1122_3344_0000);
`endif
        next();
        idle();
        sample();
        chk("ma_valid_o", 64'(valid_o), 64'd1);
        next();
        sample();
        next();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
